// File: rtl/vblank_cmd_scheduler.sv
// vblank_cmd_scheduler
//   Assembles byte-serial register-write commands into {addr,data} entries,
//   queues them in a small FIFO, and applies them to the render register file
//   only while vertical blanking is active, so updates never tear mid-frame.
//
// Ports:
//   clk, rst_n   - system clock, synchronous active-low reset
//   cmd_byte     - header/data byte from pins, valid when cmd_strobe=1
//   cmd_strobe   - one-cycle byte-valid pulse (already in clk domain)
//   vblank       - 1 while the VGA timing generator is in vertical blanking
//   reg_we       - one-cycle write enable per applied entry (registered)
//   reg_addr     - render register address (holds last written value)
//   reg_data     - render register data (holds last written value)
//   fifo_count   - queued entries
//   fifo_full    - fifo_count == FIFO_DEPTH
//   pending      - fifo_count != 0
//   overflow     - sticky: a completed WRITE was dropped; cleared by CLEAR
//
// Header byte: [7:6] opcode (00 NOP, 01 WRITE, 10 CLEAR, 11 NOP),
//              [ADDR_W-1:0] address for WRITE.
module vblank_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_W-1:0]                   cmd_byte,
  input  logic                                cmd_strobe,
  input  logic                                vblank,
  output logic                                reg_we,
  output logic [ADDR_W-1:0]                   reg_addr,
  output logic [DATA_W-1:0]                   reg_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                fifo_full,
  output logic                                pending,
  output logic                                overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = ADDR_W + DATA_W;

  typedef enum logic {
    HDR,
    DATA
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, pending_q;
  logic              ovf_q, ovf_d;

  logic              reg_we_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_data_q;

  logic              flush;
  logic              push_try;
  logic              push;
  logic              pop;

  // Assembler next state and FIFO control.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    flush    = 1'b0;
    push_try = 1'b0;

    if (cmd_strobe) begin
      unique case (state_q)
        HDR: begin
          unique case (cmd_byte[7:6])
            2'b01: begin
              addr_d  = cmd_byte[ADDR_W-1:0];
              state_d = DATA;
            end
            2'b10:   flush = 1'b1;
            default: ;
          endcase
        end
        DATA: begin
          push_try = 1'b1;
          state_d  = HDR;
        end
        default: state_d = HDR;
      endcase
    end

    pop  = vblank && (count_q != '0) && !flush;
    // A pop in the same cycle frees the slot the push is about to take.
    push = push_try && ((count_q < CW'(FIFO_DEPTH)) || pop);

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      ovf_d    = ovf_q | (push_try & ~push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HDR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= {addr_q, cmd_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      pending_q  <= 1'b0;
      ovf_q      <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= (count_d == CW'(FIFO_DEPTH));
      pending_q <= (count_d != '0);
      ovf_q     <= ovf_d;
      reg_we_q  <= pop;
      if (pop) begin
        {reg_addr_q, reg_data_q} <= mem_q[rd_ptr_q];
      end
    end
  end

  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_data   = reg_data_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign pending    = pending_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vblank_cmd_scheduler.sv
// tb_vblank_cmd_scheduler
//   Directed bench for vblank_cmd_scheduler. A queue-based reference model
//   tracks the expected outputs every cycle; literal checks pin key results.
module tb_vblank_cmd_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] cmd_byte;
  logic          cmd_strobe;
  logic          vblank;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          pending;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  vblank_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_byte  (cmd_byte),
    .cmd_strobe(cmd_strobe),
    .vblank    (vblank),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {addr,data}, a waiting-for-data flag.
  logic [AW+DW-1:0] mq[$];
  logic             m_in_data = 1'b0;
  logic [AW-1:0]    m_addr    = '0;
  logic             m_ovf     = 1'b0;
  logic             m_we      = 1'b0;
  logic [AW-1:0]    m_raddr   = '0;
  logic [DW-1:0]    m_rdata   = '0;
  bit               started   = 1'b0;

  always @(posedge clk) begin
    logic flush_v;
    logic [AW+DW-1:0] e;
    started <= 1'b1;
    if (!rst_n) begin
      mq.delete();
      m_in_data = 1'b0;
      m_addr    = '0;
      m_ovf     = 1'b0;
      m_we      = 1'b0;
      m_raddr   = '0;
      m_rdata   = '0;
    end else begin
      flush_v = cmd_strobe && !m_in_data && (cmd_byte[7:6] == 2'b10);
      m_we = 1'b0;
      if (vblank && mq.size() > 0 && !flush_v) begin
        e = mq.pop_front();
        m_we = 1'b1;
        {m_raddr, m_rdata} = e;
      end
      if (flush_v) begin
        mq.delete();
        m_ovf = 1'b0;
      end
      if (cmd_strobe) begin
        if (m_in_data) begin
          if (mq.size() < DEPTH) mq.push_back({m_addr, cmd_byte});
          else m_ovf = 1'b1;
          m_in_data = 1'b0;
        end else if (cmd_byte[7:6] == 2'b01) begin
          m_in_data = 1'b1;
          m_addr = cmd_byte[AW-1:0];
        end
      end
    end
  end

  // Observed writes, for order checks.
  logic [AW+DW-1:0] wlog[$];

  task automatic cmp(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("reg_we",     int'(reg_we),     int'(m_we));
      cmp("reg_addr",   int'(reg_addr),   int'(m_raddr));
      cmp("reg_data",   int'(reg_data),   int'(m_rdata));
      cmp("fifo_count", int'(fifo_count), mq.size());
      cmp("fifo_full",  int'(fifo_full),  int'(mq.size() == DEPTH));
      cmp("pending",    int'(pending),    int'(mq.size() != 0));
      cmp("overflow",   int'(overflow),   int'(m_ovf));
      if (reg_we === 1'b1) wlog.push_back({reg_addr, reg_data});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    cmd_byte   = b;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
  endtask

  task automatic write_cmd(input logic [AW-1:0] a, input logic [7:0] d);
    strobe(8'h40 | 8'(a));
    strobe(d);
  endtask

  task automatic chk_log(input string name, input int idx, input int a, input int d);
    if (idx < wlog.size()) begin
      cmp({name, "_addr"}, int'(wlog[idx][DW +: AW]), a);
      cmp({name, "_data"}, int'(wlog[idx][DW-1:0]),   d);
    end else begin
      cmp({name, "_present"}, 0, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_byte = '0; cmd_strobe = 1'b0; vblank = 1'b0;
    // 1. reset with strobe toggling
    cmd_byte = 8'h41; cmd_strobe = 1'b1; tick();
    cmd_strobe = 1'b0; tick();
    cmd_strobe = 1'b1; cmd_byte = 8'hA5; tick();
    cmd_strobe = 1'b0;
    cmp("rst_count", int'(fifo_count), 0);
    cmp("rst_we",    int'(reg_we),     0);
    cmp("rst_ovf",   int'(overflow),   0);
    cmp("rst_addr",  int'(reg_addr),   0);
    rst_n = 1'b1; tick();

    // 2. single write
    write_cmd(3'd1, 8'hA5);
    cmp("t2_count",   int'(fifo_count), 1);
    cmp("t2_pending", int'(pending),    1);
    cmp("t2_we0",     int'(reg_we),     0);
    vblank = 1'b1; tick();
    cmp("t2_we",    int'(reg_we),   1);
    cmp("t2_addr",  int'(reg_addr), 1);
    cmp("t2_data",  int'(reg_data), 8'hA5);
    vblank = 1'b0; tick();
    cmp("t2_count0", int'(fifo_count), 0);
    cmp("t2_we_off", int'(reg_we),     0);

    // 3. overflow
    wlog.delete();
    for (int i = 0; i < 5; i++) write_cmd(3'(i), 8'(8'h10 + i));
    cmp("t3_full",  int'(fifo_full),  1);
    cmp("t3_ovf",   int'(overflow),   1);
    cmp("t3_count", int'(fifo_count), 4);
    vblank = 1'b1; tick(6); vblank = 1'b0; tick();
    cmp("t3_nwr", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("t3_wr", i, i, 8'h10 + i);
    cmp("t3_ovf_kept", int'(overflow), 1);
    strobe(8'h80);
    cmp("t3_ovf_clr", int'(overflow), 0);

    // 4. short blanking
    wlog.delete();
    for (int i = 0; i < 4; i++) write_cmd(3'(4 + i), 8'(8'h20 + i));
    vblank = 1'b1; tick(2); vblank = 1'b0; tick();
    cmp("t4_nwr",   wlog.size(),      2);
    cmp("t4_count", int'(fifo_count), 2);
    tick(3);
    cmp("t4_hold", wlog.size(), 2);
    vblank = 1'b1; tick(3); vblank = 1'b0; tick();
    cmp("t4_nwr2", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("t4_wr", i, 4 + i, 8'h20 + i);

    // 5. full with simultaneous push and pop
    wlog.delete();
    for (int i = 0; i < 4; i++) write_cmd(3'(i), 8'(8'h30 + i));
    strobe(8'h45);
    vblank = 1'b1;
    strobe(8'h35);
    cmp("t5_count", int'(fifo_count), 4);
    cmp("t5_ovf",   int'(overflow),   0);
    tick(5); vblank = 1'b0; tick();
    cmp("t5_nwr", wlog.size(), 5);
    for (int i = 0; i < 4; i++) chk_log("t5_wr", i, i, 8'h30 + i);
    chk_log("t5_last", 4, 5, 8'h35);

    // 6a. reset mid-command
    wlog.delete();
    strobe(8'h42);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cmp("t6_we_rst", int'(reg_we), 0);
    strobe(8'h42);
    strobe(8'h11);
    vblank = 1'b1; tick(2); vblank = 1'b0; tick();
    cmp("t6_nwr", wlog.size(), 1);
    chk_log("t6_wr", 0, 2, 8'h11);

    // 6b. CLEAR wins over pop
    wlog.delete();
    for (int i = 0; i < 3; i++) write_cmd(3'(i), 8'(8'h50 + i));
    vblank = 1'b1;
    strobe(8'h80);
    tick(3); vblank = 1'b0; tick();
    cmp("t6b_nwr",   wlog.size(),      0);
    cmp("t6b_count", int'(fifo_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
